// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage integer/FP pipeline.
// Generates PC / IF-ID / ID-EX stall and flush controls plus a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_float,
  input  logic             ex_valid,
  input  logic             ex_load,
  input  logic             ex_rwrite,
  input  logic             ex_float,
  input  logic             ex_dw,
  input  logic [4:0]       ex_dst,
  input  logic             ex_multi,
  input  logic             br_taken,
  input  logic             clr_cnt,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    RUN,
    MC_BUSY
  } stateT;

  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

  stateT      state, nextState;
  logic [3:0] mcCnt, nextMcCnt;
  logic       pcStallRaw, ifidStallRaw, idexStallRaw;
  logic       ifidFlushRaw, idexFlushRaw;
  logic       rsMatch, rtMatch, hazMatch, luHaz;

  // A double-word FP write covers the even/odd pair, so bit 0 is ignored
  function automatic logic srcMatch(input logic [4:0] r, input logic [4:0] dst,
                                    input logic dw, input logic isFloat);
    logic hit;
    hit = dw ? (r[4:1] == dst[4:1]) : (r == dst);
    return hit && !(!isFloat && (r == 5'd0));
  endfunction

  always_comb begin
    rsMatch  = id_use_rs && srcMatch(id_rs, ex_dst, ex_dw, ex_float);
    rtMatch  = id_use_rt && srcMatch(id_rt, ex_dst, ex_dw, ex_float);
    hazMatch = ex_valid && ex_rwrite && (ex_float == id_float) && (rsMatch || rtMatch);
    luHaz    = hazMatch && ex_load;
  end

  // Priority: hold, multi-cycle occupancy, multi-cycle start, branch squash, load-use
  always_comb begin
    nextState    = state;
    nextMcCnt    = mcCnt;
    pcStallRaw   = 1'b0;
    ifidStallRaw = 1'b0;
    idexStallRaw = 1'b0;
    ifidFlushRaw = 1'b0;
    idexFlushRaw = 1'b0;
    if (hold) begin
      pcStallRaw   = 1'b1;
      ifidStallRaw = 1'b1;
      idexStallRaw = 1'b1;
    end else if (state == MC_BUSY) begin
      pcStallRaw   = (mcCnt > 4'd1);
      ifidStallRaw = (mcCnt > 4'd1);
      idexStallRaw = (mcCnt > 4'd1);
      if (mcCnt <= 4'd1) begin
        nextState = RUN;
        nextMcCnt = 4'd0;
      end else begin
        nextMcCnt = mcCnt - 4'd1;
      end
    end else if (ex_valid && ex_multi) begin
      pcStallRaw   = 1'b1;
      ifidStallRaw = 1'b1;
      idexStallRaw = 1'b1;
      nextMcCnt    = MC_LOAD;
      nextState    = MC_BUSY;
    end else if (br_taken) begin
      ifidFlushRaw = 1'b1;
      idexFlushRaw = 1'b1;
    end else if (luHaz) begin
      pcStallRaw   = 1'b1;
      ifidStallRaw = 1'b1;
      idexFlushRaw = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      mcCnt <= 4'd0;
    end else begin
      state <= nextState;
      mcCnt <= nextMcCnt;
    end
  end

  // Hold cycles are not counted, but a clear always takes effect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (clr_cnt) begin
      stall_count <= '0;
    end else if (pcStallRaw && !hold && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign pc_stall   = rst_n && pcStallRaw;
  assign ifid_stall = rst_n && ifidStallRaw;
  assign idex_stall = rst_n && idexStallRaw;
  assign ifid_flush = rst_n && ifidFlushRaw;
  assign idex_flush = rst_n && idexFlushRaw;
  assign busy       = rst_n && (state == MC_BUSY);

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage integer/FP pipeline. It drives the stall and flush controls of the PC, the IF/ID register and the ID/EX register. It detects load-use hazards on both register files and holds the pipeline while a multi-cycle FP operation occupies EX. It also squashes wrong-path instructions on a taken branch, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- MC_LAT, 4: total EX occupancy in cycles of a multi-cycle FP op; legal range 2..15.
- CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- hold  in  1  external freeze, e.g. memory wait.
- id_rs, id_rt  in  5  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  the ID instruction actually reads rs / rt.
- id_float  in  1  ID sources come from the FP register file.
- ex_valid  in  1  ID/EX holds a real instruction, not a bubble.
- ex_load  in  1  EX instruction is a load.
- ex_rwrite  in  1  EX instruction writes a register.
- ex_float  in  1  EX destination is in the FP file.
- ex_dw  in  1  EX writes the even/odd FP pair dst, dst+1.
- ex_dst  in  5  EX destination register.
- ex_multi  in  1  EX instruction is a multi-cycle FP op.
- br_taken  in  1  EX resolved a taken branch or jump.
- clr_cnt  in  1  synchronous clear of stall_count.
- pc_stall, ifid_stall, idex_stall  out  1  hold the corresponding register.
- ifid_flush, idex_flush  out  1  load a bubble into the register (all control fields zero).
- busy  out  1  FSM is in MC_BUSY.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- FSM states: RUN, MC_BUSY. Down-counter mc_cnt is 4 bits wide.
- All stall and flush outputs are combinational from inputs, state and mc_cnt, so they act in the same cycle.

Hazard match:
- Condition: ex_valid & ex_rwrite & (ex_float == id_float) & one of:
  - (id_use_rs & src_match(id_rs))
  - (id_use_rt & src_match(id_rt))
- src_match(r), normal case: r == ex_dst.
- src_match(r) when ex_dw: r[4:1] == ex_dst[4:1].
- Integer register 0 never matches (ex_float=0 & r=0). FP register 0 does match.
- lu_haz = hazard match & ex_load.

Output priority, evaluated each cycle:
1. hold=1: pc/ifid/idex_stall=1, both flushes=0. FSM, mc_cnt and stall_count are frozen. A pending branch or hazard is re-evaluated once hold drops.
2. MC_BUSY: stalls are 1 while mc_cnt>1 and 0 when mc_cnt==1. Flushes are 0, and br_taken and lu_haz are ignored. mc_cnt decrements each cycle. When mc_cnt==1 the next state is RUN.
3. RUN & ex_valid & ex_multi: stalls=1, load mc_cnt=MC_LAT-1, next state MC_BUSY. If MC_LAT==2, the single MC_BUSY cycle has mc_cnt==1, so there is no stall in it. This has priority over br_taken, since decode never issues both.
4. RUN & br_taken: ifid_flush=1, idex_flush=1, no stalls.
5. RUN & lu_haz: pc_stall=1, ifid_stall=1, idex_flush=1, idex_stall=0. This inserts exactly one bubble, after which the load has moved on and the hazard clears.
6. Otherwise all outputs are 0.

Other rules:
- busy = (state == MC_BUSY).
- stall_count increments on any cycle with pc_stall=1 & hold=0. It saturates at all-ones.
- clr_cnt has priority over increment, and it clears even while hold=1.

## Timing
- Reset: state=RUN, mc_cnt=0, stall_count=0. While rst_n=0 all stall/flush outputs and busy are forced to 0.
- Reset asserted mid multi-cycle op: the FSM returns to RUN immediately. No residual stall occurs after release.
- A multi-cycle op occupies ID/EX for exactly MC_LAT cycles with stalls asserted for MC_LAT-1 of them, plus any hold cycles.
- Back-to-back multi-cycle ops: after the RUN transition, the next op in ID/EX re-enters MC_BUSY in its first cycle.
- Load-use costs exactly 1 bubble. Taken branch costs exactly 2 squashed slots.

## Test plan
- Load-use: load with ex_dst=5 in EX, ID has id_use_rs=1, id_rs=5, same file. Required: pc_stall=ifid_stall=idex_flush=1 for 1 cycle. Next cycle (ex_valid=0) all outputs 0, stall_count=1. Same test with ex_dst=0 integer: no stall.
- DW pair: ex_dw=1, ex_float=1, ex_dst=6, ex_load=1, ID FP read of reg 7. Required: 1 bubble. Read of reg 8: no stall.
- Multi-cycle, MC_LAT=4: ex_multi asserted at cycle 0. Required: stalls=1 in cycles 0-2 (busy=1 in 1-3), stalls=0 in cycle 3, RUN in cycle 4, stall_count=3.
- Taken branch plus lu_haz in the same cycle. Required: both flushes=1, pc_stall=0. During MC_BUSY, br_taken=1 gives no flush.
- hold=1 for 3 cycles mid MC_BUSY with mc_cnt=2. Required: all stalls=1, mc_cnt stays 2, stall_count unchanged. After release, 1 more stalled cycle and then release as normal.
- stall_count at 0xFFFE with 3 stall cycles. Required: saturates at 0xFFFF. clr_cnt=1 together with a stall gives 0. rst_n low mid MC_BUSY gives busy=0 asynchronously.
